ins_queue: RTL and testbench
============================

// Module: ins_queue
// PURPOSE
//  Parametrised instruction register/queue between instruction memory and the control unit.
//  Buffers up to DEPTH fetched instruction words with valid/ready handshakes on both sides.
//  Presents the head word already split into opcode/address fields.
//  Supports flush (branch/jump) so the fetch stage can prefetch ahead of execute.
// PARAMETERS
//  OPC_W   5   opcode field width, taken from ins_in[INS_W-1 -: OPC_W]
//  ADDR_W  14  address field width, taken from ins_in[ADDR_W-1:0]
//  INS_W   19  instruction width; must equal OPC_W+ADDR_W (elaboration error otherwise)
//  DEPTH   4   entries; power of two, >=2
// PORTS
//  clk        in   1         clock, all logic on posedge
//  rst        in   1         synchronous, active-high reset
//  flush      in   1         discard all entries this cycle
//  ins_in     in   INS_W     instruction word from memory
//  ins_valid  in   1         ins_in valid this cycle
//  ins_ready  out  1         queue can accept (= !full, registered state only)
//  out_valid  out  1         head entry present
//  out_ready  in   1         control unit consumes head this cycle
//  opcode     out  OPC_W     head opcode field
//  address    out  ADDR_W    head address field
//  count      out  log2(DEPTH)+1  occupied entries
// BEHAVIOUR
//  - Reset: count=0, out_valid=0, opcode=0, address=0, rd/wr pointers=0; ins_ready=0 while rst high, 1 the cycle after.
//  - Push when ins_valid&&ins_ready; pop when out_valid&&out_ready. Both evaluated on the same edge.
//  - Latency: word pushed at edge N is visible on opcode/address with out_valid=1 after edge N (no same-cycle bypass).
//  - opcode/address are driven from storage at rd_ptr, forced to 0 when out_valid=0.
//  - The head is stable while out_valid && !out_ready.
//  - Pointers wrap modulo DEPTH; count = pushes - pops, never exceeds DEPTH.
//  - Full (count==DEPTH): ins_ready=0, so ins_valid is ignored. A same-cycle pop does not enable a push; ins_ready rises the next cycle.
//  - Empty: out_valid=0, so out_ready is ignored.
//  - Simultaneous push+pop (not full, not empty): count unchanged; both pointers advance.
//  - flush: wins over push and pop in the same cycle. Next cycle count=0, out_valid=0, pointers=0; the concurrent ins_in is dropped.
//  - rst has priority over flush; rst mid-stream discards all contents identically.
// CONFIGURATION
//  IR_PARITY_EN defined:
//    - adds input ins_par (1 bit, even parity over ins_in) and output par_err (1 bit).
//    - parity is stored per entry; par_err = out_valid && (^{stored word, stored par} != 0).
//    - par_err is reset to 0.
//    - an entry with a parity error is still popped normally; the consumer decides what to do.
//  IR_PARITY_EN undefined: no ins_par/par_err ports and no extra storage.
// STRUCTURE
//  - Shared package: INS_W/OPC_W/ADDR_W defaults, opcode field position localparams, and the opcode enum used by the control unit.
//  - Storage array, pointers and count live in this module; no sub-module. Field split is pure wiring at the head.
// TESTING
//  1. rst high 3 cycles, then low -> count=0, out_valid=0, opcode=0, address=0; ins_ready=1 one cycle after rst falls.
//  2. Push 19'h4_1234 with out_ready=0 -> next cycle out_valid=1, opcode=5'h10, address=14'h1234, count=1; held for 5 cycles.
//  3. Push 5 words with out_ready=0 (DEPTH=4) -> ins_ready=0 after the 4th push, 5th word dropped, count=4. Then pop all -> first 4 words out in order.
//  4. Steady push+pop every cycle for 20 cycles -> count constant at 1 and words emerge in order. Pointer wrap is exercised 5 times.
//  5. count=3, assert flush together with ins_valid and out_ready -> next cycle count=0, out_valid=0; next push appears at the head.
//  6. IR_PARITY_EN: push 19'h00001 with ins_par=0 -> par_err=1 while at the head. Push it with ins_par=1 -> par_err=0.

Source files
------------

// File: rtl/ins_queue_pkg.sv
// Shared definitions for the instruction queue between instruction memory
// and the control unit: default field widths, opcode field position and the
// opcode encoding the control unit decodes.
package ins_queue_pkg;

    // Default instruction format: [18:14] opcode, [13:0] address.
    localparam int OPC_W_DEF  = 5;
    localparam int ADDR_W_DEF = 14;
    localparam int INS_W_DEF  = OPC_W_DEF + ADDR_W_DEF;
    localparam int DEPTH_DEF  = 4;

    // Bit positions of the fields inside a default-width instruction word.
    localparam int OPC_MSB  = INS_W_DEF - 1;
    localparam int OPC_LSB  = ADDR_W_DEF;
    localparam int ADDR_MSB = ADDR_W_DEF - 1;
    localparam int ADDR_LSB = 0;

    // Opcode encoding seen by the control unit at the queue head.
    typedef enum logic [OPC_W_DEF-1:0] {
        OP_NOP   = 5'h00,
        OP_LOAD  = 5'h01,
        OP_STORE = 5'h02,
        OP_ADD   = 5'h03,
        OP_SUB   = 5'h04,
        OP_AND   = 5'h05,
        OP_OR    = 5'h06,
        OP_XOR   = 5'h07,
        OP_JMP   = 5'h10,
        OP_JZ    = 5'h11,
        OP_JNZ   = 5'h12,
        OP_CALL  = 5'h13,
        OP_RET   = 5'h14,
        OP_HALT  = 5'h1f
    } opcode_e;

endpackage

// File: rtl/ins_queue_if.sv
// Bus bundle between fetch/control and the instruction queue.
// Optional parity (macro IR_PARITY_EN) adds ins_par and par_err.
//
// Handshake rules, both sides: a word moves on a rising clk edge where
// valid && ready are both high. ins_ready depends only on registered queue
// state, never on same-cycle inputs. out_valid/opcode/address hold steady
// while out_valid && !out_ready. flush discards everything, including any
// transfer that would otherwise have happened on that edge.
interface ins_queue_if
    import ins_queue_pkg::*;
#(
    parameter int OPC_W  = OPC_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int INS_W  = INS_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              flush;
    logic [INS_W-1:0]  ins_in;
    logic              ins_valid;
    logic              ins_ready;
    logic              out_valid;
    logic              out_ready;
    logic [OPC_W-1:0]  opcode;
    logic [ADDR_W-1:0] address;
    logic [CNT_W-1:0]  count;
`ifdef IR_PARITY_EN
    logic              ins_par;
    logic              par_err;
`endif

`ifdef IR_PARITY_EN
    modport master (
        output flush, ins_in, ins_valid, out_ready, ins_par,
        input  ins_ready, out_valid, opcode, address, count, par_err
    );
    modport slave (
        input  flush, ins_in, ins_valid, out_ready, ins_par,
        output ins_ready, out_valid, opcode, address, count, par_err
    );
`else
    modport master (
        output flush, ins_in, ins_valid, out_ready,
        input  ins_ready, out_valid, opcode, address, count
    );
    modport slave (
        input  flush, ins_in, ins_valid, out_ready,
        output ins_ready, out_valid, opcode, address, count
    );
`endif

endinterface

// File: rtl/ins_queue.sv
// Instruction register/queue: buffers up to DEPTH fetched words so fetch can
// run ahead of execute, presents the head split into opcode/address, and
// drops everything on flush (taken branch/jump).
// Optional per-entry even parity is enabled with macro IR_PARITY_EN.
module ins_queue
    import ins_queue_pkg::*;
#(
    parameter int OPC_W  = OPC_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int INS_W  = INS_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
)(
    input  logic        clk,
    input  logic        rst,
    ins_queue_if.slave  bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Refuse to build with an inconsistent instruction format or depth.
    if (INS_W != OPC_W + ADDR_W) begin : g_bad_width
        $error("ins_queue: INS_W must equal OPC_W + ADDR_W");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("ins_queue: DEPTH must be a power of two and at least 2");
    end

    logic [INS_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             active_q;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [INS_W-1:0] head;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    // active_q keeps ins_ready low throughout reset and for the first edge
    // after it; ready is otherwise purely !full from registered state, so a
    // pop on a full cycle cannot open the input in that same cycle.
    assign bus.ins_ready = active_q && !full;
    assign bus.out_valid = !empty;
    assign bus.count     = count_q;

    // Flush squashes both transfers, so they are gated here once.
    assign push = bus.ins_valid && bus.ins_ready && !bus.flush;
    assign pop  = bus.out_valid && bus.out_ready && !bus.flush;

    // Pointers, occupancy and the post-reset ready enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            active_q <= 1'b0;
        end else begin
            active_q <= 1'b1;
            if (bus.flush) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count_q <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                case ({push, pop})
                    2'b10:   count_q <= count_q + CNT_W'(1);
                    2'b01:   count_q <= count_q - CNT_W'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    // Word storage; no reset needed since the head is masked while empty.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= bus.ins_in;
        end
    end

    // Head field split, forced to zero when nothing is queued.
    always_comb begin
        head        = mem[rd_ptr];
        bus.opcode  = '0;
        bus.address = '0;
        if (bus.out_valid) begin
            bus.opcode  = head[INS_W-1 -: OPC_W];
            bus.address = head[ADDR_W-1:0];
        end
    end

`ifdef IR_PARITY_EN
    logic par_mem [DEPTH];

    // Parity bit stored alongside each word.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            par_mem[wr_ptr] <= bus.ins_par;
        end
    end

    // Even parity over word+bit; flagged only while the entry is at the head.
    // The entry still pops normally, the consumer decides what to do.
    always_comb begin
        bus.par_err = 1'b0;
        if (bus.out_valid) begin
            bus.par_err = ^{mem[rd_ptr], par_mem[rd_ptr]};
        end
    end
`endif

endmodule

// File: tb/tb_ins_queue.sv
// Bench for ins_queue: a table of single-cycle vectors covering reset, hold,
// fill/overflow, drain, flush and mid-stream reset, followed by hand-written
// sequences for steady streaming with pointer wrap and, when IR_PARITY_EN is
// defined, the parity flag.
module tb_ins_queue;
    import ins_queue_pkg::*;

    localparam int OPC_W  = 5;
    localparam int ADDR_W = 14;
    localparam int INS_W  = 19;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic clk;
    logic rst;

    ins_queue_if #(.OPC_W(OPC_W), .ADDR_W(ADDR_W), .INS_W(INS_W), .DEPTH(DEPTH)) bus ();

    ins_queue #(.OPC_W(OPC_W), .ADDR_W(ADDR_W), .INS_W(INS_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic              rst;
        logic              flush;
        logic              ins_valid;
        logic              out_ready;
        logic [INS_W-1:0]  ins_in;
        logic              exp_ready;
        logic              exp_valid;
        logic [OPC_W-1:0]  exp_opc;
        logic [ADDR_W-1:0] exp_addr;
        logic [CNT_W-1:0]  exp_count;
    } vec_t;

    vec_t             vecs[$];
    logic [INS_W-1:0] exp_q[$];
    int               n_cmp = 0;
    int               n_err = 0;

    function automatic vec_t mk(input int r, input int f, input int v, input int o,
                                input int io, input int ia,
                                input int er, input int ev, input int eo, input int ea,
                                input int ec);
        vec_t m;
        m.rst       = 1'(r);
        m.flush     = 1'(f);
        m.ins_valid = 1'(v);
        m.out_ready = 1'(o);
        m.ins_in    = {OPC_W'(io), ADDR_W'(ia)};
        m.exp_ready = 1'(er);
        m.exp_valid = 1'(ev);
        m.exp_opc   = OPC_W'(eo);
        m.exp_addr  = ADDR_W'(ea);
        m.exp_count = CNT_W'(ec);
        return m;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic v, input logic o,
                         input logic [INS_W-1:0] w);
        rst           = r;
        bus.flush     = f;
        bus.ins_valid = v;
        bus.out_ready = o;
        bus.ins_in    = w;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stimulus, checks and report
    initial begin
        logic [INS_W-1:0] w;
`ifdef IR_PARITY_EN
        bus.ins_par = 1'b0;
`endif
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0);

        // reset held 3 cycles, then released
        for (int i = 0; i < 3; i++) vecs.push_back(mk(1,0,0,0, 0,0,       0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0, 0,0,                             1,0,0,0,0));
        // single word held at head for 5 cycles, then popped
        vecs.push_back(mk(0,0,1,0, 'h10,'h1234,                     1,1,'h10,'h1234,1));
        for (int i = 0; i < 5; i++) vecs.push_back(mk(0,0,0,0, 0,0, 1,1,'h10,'h1234,1));
        vecs.push_back(mk(0,0,0,1, 0,0,                             1,0,0,0,0));
        // fill to DEPTH, overflow word dropped, pop at full does not admit a push
        vecs.push_back(mk(0,0,1,0, 1,'h011,                         1,1,1,'h011,1));
        vecs.push_back(mk(0,0,1,0, 2,'h022,                         1,1,1,'h011,2));
        vecs.push_back(mk(0,0,1,0, 3,'h033,                         1,1,1,'h011,3));
        vecs.push_back(mk(0,0,1,0, 4,'h044,                         0,1,1,'h011,4));
        vecs.push_back(mk(0,0,1,0, 5,'h055,                         0,1,1,'h011,4));
        vecs.push_back(mk(0,0,1,1, 6,'h066,                         1,1,2,'h022,3));
        vecs.push_back(mk(0,0,0,1, 0,0,                             1,1,3,'h033,2));
        vecs.push_back(mk(0,0,0,1, 0,0,                             1,1,4,'h044,1));
        vecs.push_back(mk(0,0,0,1, 0,0,                             1,0,0,0,0));
        // flush at count 3 beats concurrent push and pop
        vecs.push_back(mk(0,0,1,0, 7,'h077,                         1,1,7,'h077,1));
        vecs.push_back(mk(0,0,1,0, 8,'h088,                         1,1,7,'h077,2));
        vecs.push_back(mk(0,0,1,0, 9,'h099,                         1,1,7,'h077,3));
        vecs.push_back(mk(0,1,1,1, 'h0a,'h0aa,                      1,0,0,0,0));
        vecs.push_back(mk(0,0,1,0, 'h0b,'h0bb,                      1,1,'h0b,'h0bb,1));
        vecs.push_back(mk(0,0,0,1, 0,0,                             1,0,0,0,0));
        // reset mid-stream discards contents and the concurrent word
        vecs.push_back(mk(0,0,1,0, 'h0c,'h0cc,                      1,1,'h0c,'h0cc,1));
        vecs.push_back(mk(0,0,1,0, 'h0d,'h0dd,                      1,1,'h0c,'h0cc,2));
        vecs.push_back(mk(1,0,1,0, 'h0e,'h0ee,                      0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0, 0,0,                             1,0,0,0,0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].flush, vecs[i].ins_valid, vecs[i].out_ready, vecs[i].ins_in);
            tick();
            check($sformatf("v%0d ins_ready", i), 32'(bus.ins_ready), 32'(vecs[i].exp_ready));
            check($sformatf("v%0d out_valid", i), 32'(bus.out_valid), 32'(vecs[i].exp_valid));
            check($sformatf("v%0d opcode", i),    32'(bus.opcode),    32'(vecs[i].exp_opc));
            check($sformatf("v%0d address", i),   32'(bus.address),   32'(vecs[i].exp_addr));
            check($sformatf("v%0d count", i),     32'(bus.count),     32'(vecs[i].exp_count));
        end

        // steady push+pop for 20 cycles: count stays 1, order preserved
        w = 19'h00abc;
        drive(1'b0, 1'b0, 1'b1, 1'b0, w);
        tick();
        exp_q.push_back(w);
        check("stream prime count", 32'(bus.count), 32'd1);
        for (int i = 1; i <= 20; i++) begin
            w = INS_W'(32'h1357 * i + 32'h00abc);
            drive(1'b0, 1'b0, 1'b1, 1'b1, w);
            check($sformatf("stream head %0d", i), 32'({bus.opcode, bus.address}), 32'(exp_q[0]));
            tick();
            void'(exp_q.pop_front());
            exp_q.push_back(w);
            check($sformatf("stream count %0d", i), 32'(bus.count), 32'd1);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1, '0);
        check("stream last head", 32'({bus.opcode, bus.address}), 32'(exp_q[0]));
        tick();
        void'(exp_q.pop_front());
        check("stream drained count", 32'(bus.count), 32'd0);
        check("stream drained valid", 32'(bus.out_valid), 32'd0);

`ifdef IR_PARITY_EN
        check("par_err empty", 32'(bus.par_err), 32'd0);
        bus.ins_par = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 19'h00001);
        tick();
        check("par_err bad parity", 32'(bus.par_err), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, '0);
        tick();
        check("par_err bad popped", 32'(bus.count), 32'd0);
        check("par_err after pop", 32'(bus.par_err), 32'd0);
        bus.ins_par = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 19'h00001);
        tick();
        check("par_err good parity", 32'(bus.par_err), 32'd0);
        check("par good valid", 32'(bus.out_valid), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, '0);
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
